// File: rtl/rs_station_if.sv
// Issue / dispatch / CDB bundle for rs_station.
//   slave  : the reservation station (consumes issue, CDB, flush, disp_ready)
//   master : the surrounding pipeline (drives issue, CDB, flush, disp_ready)
// Signals:
//   flush                              squash all in-flight entries
//   iss_valid/iss_ready                issue handshake
//   iss_op/rd/rs1/rs2/use_imm/imm      decoded instruction
//   disp_valid/disp_ready              dispatch handshake to the functional unit
//   disp_tag/op/vj/vk                  presented entry
//   cdb_valid/cdb_tag/cdb_data         common data bus broadcast
//   full                               no free entry
interface rs_station_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = 17
);
  logic             flush;
  logic             iss_valid;
  logic             iss_ready;
  logic [OP_W-1:0]  iss_op;
  logic [4:0]       iss_rd;
  logic [4:0]       iss_rs1;
  logic [4:0]       iss_rs2;
  logic             iss_use_imm;
  logic [XLEN-1:0]  iss_imm;
  logic             disp_valid;
  logic             disp_ready;
  logic [TAG_W-1:0] disp_tag;
  logic [OP_W-1:0]  disp_op;
  logic [XLEN-1:0]  disp_vj;
  logic [XLEN-1:0]  disp_vk;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  logic             full;

  modport slave (
    input  flush, iss_valid, iss_op, iss_rd, iss_rs1, iss_rs2, iss_use_imm, iss_imm,
    input  disp_ready, cdb_valid, cdb_tag, cdb_data,
    output iss_ready, disp_valid, disp_tag, disp_op, disp_vj, disp_vk, full
  );

  modport master (
    output flush, iss_valid, iss_op, iss_rd, iss_rs1, iss_rs2, iss_use_imm, iss_imm,
    output disp_ready, cdb_valid, cdb_tag, cdb_data,
    input  iss_ready, disp_valid, disp_tag, disp_op, disp_vj, disp_vk, full
  );
endinterface

// File: rtl/rs_station.sv
// Reservation station with integrated register-status table.
// Renames sources at issue, snoops the CDB for results, and presents the
// lowest-index READY entry to a functional unit. Tags are entry index + 1;
// tag 0 means "value present".
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rs_station_if.slave (issue, dispatch, CDB, flush, full)
module rs_station #(
  parameter int XLEN     = 32,
  parameter int RS_DEPTH = 4,
  parameter int TAG_W    = 4,
  parameter int NREG     = 32,
  parameter int OP_W     = 17
) (
  input logic         clk,
  input logic         rst_n,
  rs_station_if.slave bus
);

  localparam logic [1:0] S_FREE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_EXEC  = 2'd3;

  logic [1:0]       st    [RS_DEPTH];
  logic [OP_W-1:0]  e_op  [RS_DEPTH];
  logic [XLEN-1:0]  e_vj  [RS_DEPTH];
  logic [XLEN-1:0]  e_vk  [RS_DEPTH];
  logic [TAG_W-1:0] e_qj  [RS_DEPTH];
  logic [TAG_W-1:0] e_qk  [RS_DEPTH];

  logic [XLEN-1:0]  reg_val [NREG];
  logic [TAG_W-1:0] reg_tag [NREG];

  logic [RS_DEPTH-1:0] free_oh, rdy_oh, j_hit, k_hit;
  logic                free_found, rdy_found;
  logic [TAG_W-1:0]    free_tag, sel_tag;
  logic [OP_W-1:0]     sel_op;
  logic [XLEN-1:0]     sel_vj, sel_vk;
  logic                iss_fire, disp_fire, cdb_hit;

  logic [XLEN-1:0]     rv1, rv2, vj_new, vk_new;
  logic [TAG_W-1:0]    rt1, rt2, qj_new, qk_new;

  // Lowest-index FREE and READY entries, as one-hot selects.
  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    free_tag   = '0;
    rdy_oh     = '0;
    rdy_found  = 1'b0;
    sel_tag    = '0;
    sel_op     = '0;
    sel_vj     = '0;
    sel_vk     = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (!free_found && st[i] == S_FREE) begin
        free_found = 1'b1;
        free_oh[i] = 1'b1;
        free_tag   = TAG_W'(i + 1);
      end
      if (!rdy_found && st[i] == S_READY) begin
        rdy_found = 1'b1;
        rdy_oh[i] = 1'b1;
        sel_tag   = TAG_W'(i + 1);
        sel_op    = e_op[i];
        sel_vj    = e_vj[i];
        sel_vk    = e_vk[i];
      end
    end
  end

  // disp_valid is masked by flush so the functional unit never sees a
  // handshake that the station would drop.
  assign bus.full       = !free_found;
  assign bus.iss_ready  = free_found && !bus.flush;
  assign bus.disp_valid = rdy_found && !bus.flush;
  assign bus.disp_tag   = sel_tag;
  assign bus.disp_op    = sel_op;
  assign bus.disp_vj    = sel_vj;
  assign bus.disp_vk    = sel_vk;

  assign iss_fire  = bus.iss_valid && bus.iss_ready;
  assign disp_fire = bus.disp_valid && bus.disp_ready;
  assign cdb_hit   = bus.cdb_valid && (bus.cdb_tag != '0) && !bus.flush;

  always_comb begin
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      j_hit[i] = cdb_hit && (e_qj[i] == bus.cdb_tag);
      k_hit[i] = cdb_hit && (e_qk[i] == bus.cdb_tag);
    end
  end

  // Source rename with same-cycle CDB bypass. Register 0 is never matched,
  // so it reads as value 0 with tag 0.
  always_comb begin
    rv1 = '0;
    rt1 = '0;
    rv2 = '0;
    rt2 = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (bus.iss_rs1 == 5'(r)) begin
        rv1 = reg_val[r];
        rt1 = reg_tag[r];
      end
      if (bus.iss_rs2 == 5'(r)) begin
        rv2 = reg_val[r];
        rt2 = reg_tag[r];
      end
    end
    vj_new = rv1;
    qj_new = '0;
    if (rt1 != '0) begin
      if (bus.cdb_valid && bus.cdb_tag == rt1) begin
        vj_new = bus.cdb_data;
      end else begin
        vj_new = '0;
        qj_new = rt1;
      end
    end
    vk_new = rv2;
    qk_new = '0;
    if (bus.iss_use_imm) begin
      vk_new = bus.iss_imm;
    end else if (rt2 != '0) begin
      if (bus.cdb_valid && bus.cdb_tag == rt2) begin
        vk_new = bus.cdb_data;
      end else begin
        vk_new = '0;
        qk_new = rt2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        st[i]   <= S_FREE;
        e_op[i] <= '0;
        e_vj[i] <= '0;
        e_vk[i] <= '0;
        e_qj[i] <= '0;
        e_qk[i] <= '0;
      end
      for (int unsigned r = 0; r < NREG; r++) begin
        reg_val[r] <= '0;
        reg_tag[r] <= '0;
      end
    end else if (bus.flush) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) st[i] <= S_FREE;
      for (int unsigned r = 0; r < NREG; r++) reg_tag[r] <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        case (st[i])
          S_WAIT: begin
            if (j_hit[i]) begin
              e_vj[i] <= bus.cdb_data;
              e_qj[i] <= '0;
            end
            if (k_hit[i]) begin
              e_vk[i] <= bus.cdb_data;
              e_qk[i] <= '0;
            end
            if ((e_qj[i] == '0 || j_hit[i]) && (e_qk[i] == '0 || k_hit[i]))
              st[i] <= S_READY;
          end
          S_READY: if (disp_fire && rdy_oh[i]) st[i] <= S_EXEC;
          S_EXEC:  if (cdb_hit && bus.cdb_tag == TAG_W'(i + 1)) st[i] <= S_FREE;
          default: begin
            if (iss_fire && free_oh[i]) begin
              st[i]   <= (qj_new == '0 && qk_new == '0) ? S_READY : S_WAIT;
              e_op[i] <= bus.iss_op;
              e_vj[i] <= vj_new;
              e_vk[i] <= vk_new;
              e_qj[i] <= qj_new;
              e_qk[i] <= qk_new;
            end
          end
        endcase
      end
      // The rename follows the CDB clear so a same-cycle issue keeps its tag
      // while the broadcast value is still written.
      for (int unsigned r = 1; r < NREG; r++) begin
        if (cdb_hit && reg_tag[r] == bus.cdb_tag) begin
          reg_val[r] <= bus.cdb_data;
          reg_tag[r] <= '0;
        end
        if (iss_fire && bus.iss_rd == 5'(r)) reg_tag[r] <= free_tag;
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: a driver issues directed then random
// stimulus and advances a behavioural model, pushing expected per-cycle status
// and expected dispatch transactions; a monitor pops and compares.
module tb_rs_station;

  localparam int XLEN = 32;
  localparam int D    = 4;
  localparam int TW   = 4;
  localparam int OPW  = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_station_if #(.XLEN(XLEN), .TAG_W(TW), .OP_W(OPW)) bus ();

  rs_station #(.XLEN(XLEN), .RS_DEPTH(D), .TAG_W(TW), .NREG(32), .OP_W(OPW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit fl; bit iv; logic [16:0] op; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    bit ui; logic [31:0] imm; bit dr; bit cv; logic [3:0] ct; logic [31:0] cd;
  } stim_t;
  typedef struct { bit rdy; bit full; bit dv; logic [3:0] tag; logic [16:0] op; logic [31:0] vj; logic [31:0] vk; } stat_t;
  typedef struct { logic [3:0] tag; logic [16:0] op; logic [31:0] vj; logic [31:0] vk; } txn_t;

  stat_t stat_q[$];
  txn_t  txn_q[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference model: per-tag entry record plus architectural register status.
  bit          m_busy [16];
  bit          m_ex   [16];
  logic [16:0] m_op   [16];
  logic [31:0] m_vj   [16];
  logic [31:0] m_vk   [16];
  logic [3:0]  m_qj   [16];
  logic [3:0]  m_qk   [16];
  logic [31:0] m_rv   [32];
  logic [3:0]  m_rt   [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t iss(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input bit ui, input logic [31:0] imm);
    stim_t s = idle();
    s.iv = 1; s.op = 17'h00013; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.ui = ui; s.imm = imm;
    return s;
  endfunction

  function automatic stim_t cdb(input logic [3:0] t, input logic [31:0] d);
    stim_t s = idle();
    s.cv = 1; s.ct = t; s.cd = d;
    return s;
  endfunction

  function automatic stim_t acc();
    stim_t s = idle();
    s.dr = 1;
    return s;
  endfunction

  task automatic read_src(input logic [4:0] rs, input stim_t s, output logic [31:0] v, output logic [3:0] q);
    v = 0; q = 0;
    if (rs == 0) begin v = 0; q = 0; end
    else if (m_rt[rs] == 0) v = m_rv[rs];
    else if (s.cv && s.ct == m_rt[rs]) v = s.cd;
    else q = m_rt[rs];
  endtask

  function automatic stim_t rnd();
    stim_t s = idle();
    int ex[$];
    s.fl  = ($urandom_range(0, 39) == 0);
    s.iv  = ($urandom_range(0, 9) < 6);
    s.op  = 17'($urandom);
    s.rd  = 5'($urandom_range(0, 7));
    s.rs1 = 5'($urandom_range(0, 7));
    s.rs2 = 5'($urandom_range(0, 7));
    s.ui  = ($urandom_range(0, 9) < 3);
    s.imm = $urandom;
    s.dr  = ($urandom_range(0, 9) < 6);
    for (int t = 1; t <= D; t++) if (m_busy[t] && m_ex[t]) ex.push_back(t);
    if ($urandom_range(0, 1) == 1) begin
      s.cv = 1;
      s.cd = $urandom;
      if (ex.size() > 0 && $urandom_range(0, 5) != 0)
        s.ct = 4'(ex[$urandom_range(0, ex.size() - 1)]);
      else
        s.ct = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(D + 1, 15));
    end
    return s;
  endfunction

  // One cycle: drive inputs, record expectations, advance the model.
  task automatic step(input stim_t s);
    int free_t = 0;
    int rdy_t = 0;
    stat_t e;
    logic [31:0] vj, vk;
    logic [3:0]  qj, qk;
    bit do_iss;
    @(negedge clk);
    bus.flush = s.fl; bus.iss_valid = s.iv; bus.iss_op = s.op; bus.iss_rd = s.rd;
    bus.iss_rs1 = s.rs1; bus.iss_rs2 = s.rs2; bus.iss_use_imm = s.ui; bus.iss_imm = s.imm;
    bus.disp_ready = s.dr; bus.cdb_valid = s.cv; bus.cdb_tag = s.ct; bus.cdb_data = s.cd;
    for (int t = 1; t <= D; t++) begin
      if (!m_busy[t] && free_t == 0) free_t = t;
      if (m_busy[t] && !m_ex[t] && m_qj[t] == 0 && m_qk[t] == 0 && rdy_t == 0) rdy_t = t;
    end
    e.rdy = (free_t != 0) && !s.fl;
    e.full = (free_t == 0);
    e.dv  = (rdy_t != 0) && !s.fl;
    e.tag = 4'(rdy_t);
    e.op  = (rdy_t != 0) ? m_op[rdy_t] : '0;
    e.vj  = (rdy_t != 0) ? m_vj[rdy_t] : '0;
    e.vk  = (rdy_t != 0) ? m_vk[rdy_t] : '0;
    stat_q.push_back(e);
    if (e.dv && s.dr) txn_q.push_back('{e.tag, e.op, e.vj, e.vk});
    if (s.fl) begin
      for (int t = 0; t < 16; t++) begin m_busy[t] = 0; m_ex[t] = 0; end
      for (int r = 0; r < 32; r++) m_rt[r] = 0;
    end else begin
      do_iss = s.iv && e.rdy;
      read_src(s.rs1, s, vj, qj);
      if (s.ui) begin vk = s.imm; qk = 0; end
      else read_src(s.rs2, s, vk, qk);
      if (s.cv && s.ct != 0) begin
        for (int t = 1; t <= D; t++) begin
          if (m_busy[t] && !m_ex[t]) begin
            if (m_qj[t] == s.ct) begin m_vj[t] = s.cd; m_qj[t] = 0; end
            if (m_qk[t] == s.ct) begin m_vk[t] = s.cd; m_qk[t] = 0; end
          end
          if (m_busy[t] && m_ex[t] && t == int'(s.ct)) begin m_busy[t] = 0; m_ex[t] = 0; end
        end
        for (int r = 1; r < 32; r++)
          if (m_rt[r] == s.ct) begin m_rv[r] = s.cd; m_rt[r] = 0; end
      end
      if (e.dv && s.dr) m_ex[rdy_t] = 1;
      if (do_iss) begin
        m_busy[free_t] = 1; m_ex[free_t] = 0; m_op[free_t] = s.op;
        m_vj[free_t] = vj; m_qj[free_t] = qj; m_vk[free_t] = vk; m_qk[free_t] = qk;
        if (s.rd != 0) m_rt[s.rd] = 4'(free_t);
      end
    end
  endtask

  // Monitor: compares status every cycle and pops a dispatch on each handshake.
  initial begin
    stat_t e;
    txn_t  x;
    forever begin
      @(negedge clk);
      #2;
      if (stat_q.size() != 0) begin
        e = stat_q.pop_front();
        chk("iss_ready", 32'(bus.iss_ready), 32'(e.rdy));
        chk("full", 32'(bus.full), 32'(e.full));
        chk("disp_valid", 32'(bus.disp_valid), 32'(e.dv));
        chk("disp_tag", 32'(bus.disp_tag), 32'(e.tag));
        chk("disp_op", 32'(bus.disp_op), 32'(e.op));
        chk("disp_vj", bus.disp_vj, e.vj);
        chk("disp_vk", bus.disp_vk, e.vk);
        if (bus.disp_valid && bus.disp_ready) begin
          if (txn_q.size() == 0) begin
            n_total++;
            $display("FAIL dispatch_unexpected: got tag %0d expected none", bus.disp_tag);
          end else begin
            x = txn_q.pop_front();
            chk("txn_tag", 32'(bus.disp_tag), 32'(x.tag));
            chk("txn_op", 32'(bus.disp_op), 32'(x.op));
            chk("txn_vj", bus.disp_vj, x.vj);
            chk("txn_vk", bus.disp_vk, x.vk);
          end
        end
        if (txn_q.size() != 0) begin
          n_total++;
          $display("FAIL dispatch_missing: got no handshake expected tag %0d", txn_q[0].tag);
          txn_q.delete();
        end
      end
    end
  end

  initial begin
    stim_t s;
    for (int t = 0; t < 16; t++) begin
      m_busy[t] = 0; m_ex[t] = 0; m_op[t] = 0; m_vj[t] = 0; m_vk[t] = 0; m_qj[t] = 0; m_qk[t] = 0;
    end
    for (int r = 0; r < 32; r++) begin m_rv[r] = 0; m_rt[r] = 0; end
    s = idle();
    bus.flush = 0; bus.iss_valid = 0; bus.iss_op = 0; bus.iss_rd = 0; bus.iss_rs1 = 0;
    bus.iss_rs2 = 0; bus.iss_use_imm = 0; bus.iss_imm = 0; bus.disp_ready = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then ADDI x5 = x0 + 7 through dispatch and writeback.
    step(idle());
    step(iss(5, 0, 0, 1, 32'd7));
    step(acc());
    step(cdb(4'd1, 32'd7));
    // Dependent issue waits on tag 1 and wakes from the CDB.
    step(iss(5, 0, 0, 1, 32'd1));
    step(iss(6, 5, 0, 0, 32'd0));
    step(acc());
    step(cdb(4'd1, 32'h10));
    step(acc());
    step(cdb(4'd2, 32'h55));
    // Same-cycle bypass from the CDB into a new issue.
    step(iss(5, 0, 0, 1, 32'd3));
    step(acc());
    s = iss(7, 5, 0, 0, 32'd0); s.cv = 1; s.ct = 4'd1; s.cd = 32'hAB;
    step(s);
    step(acc());
    step(cdb(4'd2, 32'd1));
    // Fill every entry, try an extra issue, free tag 2, reallocate it.
    for (int i = 0; i < D; i++) step(iss(0, 0, 0, 1, 32'(100 + i)));
    step(iss(9, 0, 0, 1, 32'd99));
    step(acc());
    step(acc());
    step(cdb(4'd2, 32'd5));
    step(iss(0, 0, 0, 1, 32'd9));
    s = idle(); s.fl = 1; step(s);
    // Two READY entries held under back-pressure, then flush with 3 busy.
    step(iss(8, 0, 0, 1, 32'd11));
    step(iss(9, 8, 0, 0, 32'd0));
    step(iss(10, 0, 0, 1, 32'd22));
    repeat (3) step(idle());
    step(acc());
    step(idle());
    s = idle(); s.fl = 1; step(s);
    step(cdb(4'd2, 32'hDEAD));
    step(iss(0, 9, 8, 0, 32'd0));
    step(acc());
    step(cdb(4'd1, 32'd0));

    for (int i = 0; i < 3000; i++) step(rnd());
    step(idle());

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
